// File: rtl/multdiv_sequencer.sv
// Iterative signed 32-bit multiply (Booth radix-2) / divide (restoring) unit
// with a start/ready handshake for the processor execute stage.
module multdiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  // state   | meaning
  // IDLE    | waiting for ctrl_MULT / ctrl_DIV
  // MUL_RUN | one Booth step per cycle on the product register
  // DIV_RUN | one restoring-divide step per cycle on |A| / |B|
  // DONE    | result ready; outputs register on the following edge
  typedef enum logic [1:0] {IDLE, MUL_RUN, DIV_RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  state_t             state;
  logic [CNT_W-1:0]   count;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH:0]   prod;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   quo;
  logic               is_div;
  logic               q_neg;
  logic               div_exc;

  logic [WIDTH-1:0]   booth_hi;
  logic [WIDTH:0]     booth_sum;
  logic [2*WIDTH:0]   prod_next;
  logic               mul_ovf;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH+1:0]   div_diff;
  logic               div_ge;
  logic [WIDTH-1:0]   rem_next;
  logic [WIDTH-1:0]   quo_next;
  logic [WIDTH-1:0]   quo_final;
  logic [WIDTH-1:0]   a_abs;
  logic [WIDTH-1:0]   b_abs;
  logic               start_ok;

  always_comb begin
    booth_hi  = prod[2*WIDTH:WIDTH+1];
    booth_sum = {booth_hi[WIDTH-1], booth_hi};
    // Extra sign bit absorbs the overflow of hi -/+ MIN before the shift
    case (prod[1:0])
      2'b01:   booth_sum = {booth_hi[WIDTH-1], booth_hi} + {mcand[WIDTH-1], mcand};
      2'b10:   booth_sum = {booth_hi[WIDTH-1], booth_hi} - {mcand[WIDTH-1], mcand};
      default: booth_sum = {booth_hi[WIDTH-1], booth_hi};
    endcase
    prod_next = {booth_sum, prod[WIDTH:1]};
    mul_ovf   = !((&prod[2*WIDTH:WIDTH]) || (~|prod[2*WIDTH:WIDTH]));

    div_shift = {rem, quo[WIDTH-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, mcand};
    div_ge    = (div_diff[WIDTH+1:WIDTH] == 2'b00);
    if (div_ge) begin
      rem_next = div_diff[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_next = div_shift[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b0};
    end
    quo_final = q_neg ? (~quo + 1'b1) : quo;

    a_abs    = data_operandA[WIDTH-1] ? (~data_operandA + 1'b1) : data_operandA;
    b_abs    = data_operandB[WIDTH-1] ? (~data_operandB + 1'b1) : data_operandB;
    start_ok = (state == IDLE) || (state == DONE);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state          <= IDLE;
      count          <= '0;
      mcand          <= '0;
      prod           <= '0;
      rem            <= '0;
      quo            <= '0;
      is_div         <= 1'b0;
      q_neg          <= 1'b0;
      div_exc        <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      busy           <= (state != IDLE);
      data_resultRDY <= (state == DONE);
      if (state == DONE) begin
        data_result    <= is_div ? quo_final : prod[WIDTH:1];
        data_exception <= is_div ? div_exc : mul_ovf;
      end

      case (state)
        MUL_RUN: begin
          prod  <= prod_next;
          count <= count + 1'b1;
          if (count == LAST) state <= DONE;
        end
        DIV_RUN: begin
          rem   <= rem_next;
          quo   <= quo_next;
          count <= count + 1'b1;
          if (count == LAST) state <= DONE;
        end
        default: state <= IDLE;
      endcase

      // A start in DONE is accepted; outputs above still use the old operation
      if (start_ok) begin
        if (ctrl_MULT) begin
          state  <= MUL_RUN;
          count  <= '0;
          is_div <= 1'b0;
          mcand  <= data_operandA;
          prod   <= {{WIDTH{1'b0}}, data_operandB, 1'b0};
        end else if (ctrl_DIV) begin
          count   <= '0;
          is_div  <= 1'b1;
          rem     <= '0;
          if (data_operandB == '0) begin
            state   <= DONE;
            quo     <= '0;
            q_neg   <= 1'b0;
            div_exc <= 1'b1;
          end else begin
            state   <= DIV_RUN;
            quo     <= a_abs;
            mcand   <= b_abs;
            q_neg   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            div_exc <= (data_operandA == MIN_VAL) && (&data_operandB);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Directed-vector bench for multdiv_sequencer: arithmetic, latency, busy window,
// handshake arbitration and mid-operation reset.
module tb_multdiv_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  multdiv_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Returns just after an edge: the values seen are those of the new cycle
  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Start sampled at edge 0; cycle c is the interval after edge c
  task automatic run_op(input string tag, input logic mul, input logic div,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input logic exc, input int lat);
    int rdy_cyc;
    int rdy_cnt;
    int busy_bad;
    logic [31:0] got_res;
    logic        got_exc;
    rdy_cyc  = -1;
    rdy_cnt  = 0;
    busy_bad = 0;
    got_res  = 'x;
    got_exc  = 1'bx;
    ctrl_MULT = mul;
    ctrl_DIV  = div;
    data_operandA = a;
    data_operandB = b;
    tick;
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
    if (busy !== 1'b0) busy_bad++;
    for (int c = 1; c <= lat + 3; c++) begin
      tick;
      if (busy !== (c <= lat)) busy_bad++;
      if (data_resultRDY === 1'b1) begin
        rdy_cnt++;
        if (rdy_cyc < 0) begin
          rdy_cyc = c;
          got_res = data_result;
          got_exc = data_exception;
        end
      end
    end
    check({tag, "_lat"}, rdy_cyc, lat);
    check({tag, "_rdy_cnt"}, rdy_cnt, 1);
    check({tag, "_res"}, got_res, res);
    check({tag, "_exc"}, {31'd0, got_exc}, {31'd0, exc});
    check({tag, "_busy_bad"}, busy_bad, 0);
  endtask

  initial begin
    int rdy_cnt;
    int rdy_cyc[2];
    logic [31:0] rdy_res[2];

    reset = 1'b0;
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    repeat (3) tick;
    check("rst_result", data_result, 32'd0);
    check("rst_flags", {29'd0, data_exception, data_resultRDY, busy}, 32'd0);
    reset = 1'b1;
    tick;

    run_op("mul_6x7",      1, 0, 32'd6,          32'd7,          32'd42,         0, 33);
    run_op("mul_neg5x3",   1, 0, 32'hFFFF_FFFB,  32'd3,          32'hFFFF_FFF1,  0, 33);
    run_op("mul_ovf",      1, 0, 32'h0001_0000,  32'h0001_0000,  32'd0,          1, 33);
    run_op("mul_minxm1",   1, 0, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1, 33);
    run_op("mul_m1xm1",    1, 0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          0, 33);
    run_op("div_100_m7",   0, 1, 32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2,  0, 33);
    run_op("div_m100_7",   0, 1, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  0, 33);
    run_op("div_7_100",    0, 1, 32'd7,          32'd100,        32'd0,          0, 33);
    run_op("div_m7_m2",    0, 1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          0, 33);
    run_op("div_min_m1",   0, 1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1, 33);
    run_op("div_by_zero",  0, 1, 32'd5,          32'd0,          32'd0,          1, 1);
    run_op("both_mulwins", 1, 1, 32'd6,          32'd7,          32'd42,         0, 33);

    // DIV while busy is dropped; MULT sampled in DONE is accepted
    rdy_cnt = 0;
    rdy_cyc = '{-1, -1};
    rdy_res = '{32'hx, 32'hx};
    ctrl_MULT = 1'b1;
    data_operandA = 32'd6;
    data_operandB = 32'd7;
    tick;
    ctrl_MULT = 1'b0;
    for (int c = 1; c <= 70; c++) begin
      tick;
      if (data_resultRDY === 1'b1) begin
        if (rdy_cnt < 2) begin
          rdy_cyc[rdy_cnt] = c;
          rdy_res[rdy_cnt] = data_result;
        end
        rdy_cnt++;
      end
      ctrl_DIV  = (c == 4);
      ctrl_MULT = (c == 32);
      if (c == 4) begin
        data_operandA = 32'd50;
        data_operandB = 32'd5;
      end
      if (c == 32) begin
        data_operandA = 32'd3;
        data_operandB = 32'd5;
      end
    end
    check("b2b_rdy_cnt", rdy_cnt, 2);
    check("b2b_cyc0", rdy_cyc[0], 33);
    check("b2b_res0", rdy_res[0], 32'd42);
    check("b2b_cyc1", rdy_cyc[1], 66);
    check("b2b_res1", rdy_res[1], 32'd15);

    // Reset in cycle 10 of a multiply aborts it
    ctrl_MULT = 1'b1;
    data_operandA = 32'd9;
    data_operandB = 32'd9;
    tick;
    ctrl_MULT = 1'b0;
    repeat (9) tick;
    reset = 1'b0;
    tick;
    check("abort_result", data_result, 32'd0);
    check("abort_flags", {29'd0, data_exception, data_resultRDY, busy}, 32'd0);
    reset = 1'b1;
    rdy_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      tick;
      if (data_resultRDY === 1'b1 || busy === 1'b1) rdy_cnt++;
    end
    check("abort_no_rdy", rdy_cnt, 0);
    run_op("mul_2x3", 1, 0, 32'd2, 32'd3, 32'd6, 0, 33);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
